// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: request opcodes,
// controller FSM states and default memory/stack depths.
package mem_pkg;

    // Request opcodes as presented on ReqOp
    typedef enum logic [1:0] {
        OpLoad  = 2'b00,
        OpStore = 2'b01,
        OpPush  = 2'b10,
        OpPop   = 2'b11
    } memOp_e;

    // Controller sequencing states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } ctrlState_e;

    localparam int unsigned DefMemDepth = 200;
    localparam int unsigned DefStkDepth = 200;

    // STORE and PUSH write the RAM; LOAD and POP read it
    function automatic logic isWriteOp(memOp_e op);
        return (op == OpStore) || (op == OpPush);
    endfunction

    // PUSH and POP address the stack region of the RAM block
    function automatic logic isStackOp(memOp_e op);
        return (op == OpPush) || (op == OpPop);
    endfunction

endpackage

// File: rtl/stack_pointer_ctr.sv
// Stack entry counter with guarded increment/decrement and full/empty flags.
module stack_pointer_ctr
    import mem_pkg::*;
#(
    parameter int unsigned Depth = DefStkDepth,
    parameter int unsigned SpW   = $clog2(Depth + 1)
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Inc,
    input  logic           Dec,
    output logic [SpW-1:0] Count,
    output logic           Full,
    output logic           Empty
);

    localparam logic [SpW-1:0] DepthW = SpW'(Depth);

    logic [SpW-1:0] countQ;

    // Entry count register; a strobe against a full/empty stack is ignored
    always_ff @(posedge Clock) begin
        if (Reset) begin
            countQ <= '0;
        end else if (Inc && !Full) begin
            countQ <= countQ + 1'b1;
        end else if (Dec && !Empty) begin
            countQ <= countQ - 1'b1;
        end
    end

    assign Count = countQ;
    assign Full  = (countQ == DepthW);
    assign Empty = (countQ == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request sequencer in front of the RAM/stack block.
// Accepts LOAD/STORE/PUSH/POP, owns the stack pointer, drives registered
// RAM controls and returns one response (with error flag) per request.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_DEPTH = DefMemDepth,
    parameter int unsigned STK_DEPTH = DefStkDepth,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              RspErr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDataIn,
    output logic              MemWrite,
    output logic              MemUseStk,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic [ADDR_W-1:0] StackPointer,
    output logic              StkFull,
    output logic              StkEmpty
);

    localparam int unsigned    SpW       = $clog2(STK_DEPTH + 1);
    localparam int unsigned    WaitW     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [WaitW-1:0] LastWait = WaitW'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] MemDepthA = ADDR_W'(MEM_DEPTH);

    ctrlState_e stateQ, stateD;
    memOp_e     opQ, opD;
    logic       errQ, errD;

    logic [ADDR_W-1:0] memAddrQ, memAddrD;
    logic [DATA_W-1:0] memDataInQ, memDataInD;
    logic              memWriteQ, memWriteD;
    logic              memUseStkQ, memUseStkD;
    logic [DATA_W-1:0] rspDataQ, rspDataD;
    logic [WaitW-1:0]  waitCntQ, waitCntD;

    memOp_e         reqOp;
    logic           reqErr;
    logic [SpW-1:0] spCount;
    logic           spFull, spEmpty;
    logic           spInc, spDec;
    logic           rspPhase;

    assign reqOp = memOp_e'(ReqOp);

    stack_pointer_ctr #(
        .Depth (STK_DEPTH),
        .SpW   (SpW)
    ) u_sp (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (spInc),
        .Dec   (spDec),
        .Count (spCount),
        .Full  (spFull),
        .Empty (spEmpty)
    );

    // Classify the offered request; rejected requests never touch the RAM
    always_comb begin
        reqErr = 1'b0;
        unique case (reqOp)
            OpLoad, OpStore: reqErr = (ReqAddr >= MemDepthA);
            OpPush:          reqErr = spFull;
            OpPop:           reqErr = spEmpty;
            default:         reqErr = 1'b0;
        endcase
    end

    // Next-state and datapath update for the sequencer
    always_comb begin
        stateD     = stateQ;
        opD        = opQ;
        errD       = errQ;
        memAddrD   = memAddrQ;
        memDataInD = memDataInQ;
        memWriteD  = 1'b0;
        memUseStkD = memUseStkQ;
        rspDataD   = rspDataQ;
        waitCntD   = waitCntQ;
        spInc      = 1'b0;
        spDec      = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (ReqValid) begin
                    opD      = reqOp;
                    errD     = reqErr;
                    rspDataD = '0;
                    waitCntD = '0;
                    if (reqErr) begin
                        stateD = StResp;
                    end else begin
                        stateD     = StIssue;
                        memDataInD = ReqData;
                        memWriteD  = isWriteOp(reqOp);
                        memUseStkD = isStackOp(reqOp);
                        unique case (reqOp)
                            OpPush:  memAddrD = ADDR_W'(spCount);
                            OpPop:   memAddrD = ADDR_W'(spCount - 1'b1);
                            default: memAddrD = ReqAddr;
                        endcase
                    end
                end
            end
            StIssue: begin
                // SP moves only after the RAM has seen the pre-update address
                spInc  = (opQ == OpPush);
                spDec  = (opQ == OpPop);
                stateD = isWriteOp(opQ) ? StResp : StWait;
            end
            StWait: begin
                if (waitCntQ == LastWait) begin
                    rspDataD = MemDataOut;
                    stateD   = StResp;
                end else begin
                    waitCntD = waitCntQ + 1'b1;
                end
            end
            StResp: begin
                rspDataD = '0;
                stateD   = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    // State and registered datapath; reset aborts any in-flight request
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ     <= StIdle;
            opQ        <= OpLoad;
            errQ       <= 1'b0;
            memAddrQ   <= '0;
            memDataInQ <= '0;
            memWriteQ  <= 1'b0;
            memUseStkQ <= 1'b0;
            rspDataQ   <= '0;
            waitCntQ   <= '0;
        end else begin
            stateQ     <= stateD;
            opQ        <= opD;
            errQ       <= errD;
            memAddrQ   <= memAddrD;
            memDataInQ <= memDataInD;
            memWriteQ  <= memWriteD;
            memUseStkQ <= memUseStkD;
            rspDataQ   <= rspDataD;
            waitCntQ   <= waitCntD;
        end
    end

    // Gate strobes with Reset so nothing escapes while reset is held
    assign rspPhase     = (stateQ == StResp) && !Reset;
    assign ReqReady     = (stateQ == StIdle);
    assign RspValid     = rspPhase;
    assign RspErr       = rspPhase && errQ;
    assign RspData      = rspDataQ;
    assign MemAddr      = memAddrQ;
    assign MemDataIn    = memDataInQ;
    assign MemWrite     = memWriteQ && !Reset;
    assign MemUseStk    = memUseStkQ;
    assign StackPointer = ADDR_W'(spCount);
    assign StkFull      = spFull;
    assign StkEmpty     = spEmpty;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural RAM/stack
// block and a queue-based reference model of request semantics.
module tb_mem_access_ctrl;

    localparam int MemDepth = 200;
    localparam int StkDepth = 200;
    localparam int ReadLat  = 1;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] PU = 2'b10;
    localparam logic [1:0] PO = 2'b11;

    logic        Clock, Reset, ReqValid, ReqReady, RspValid, RspErr;
    logic        MemWrite, MemUseStk, StkFull, StkEmpty;
    logic [1:0]  ReqOp;
    logic [31:0] ReqAddr, ReqData, RspData, MemAddr, MemDataIn, MemDataOut, StackPointer;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    logic [31:0] refMem [0:MemDepth-1];
    logic [31:0] refStack [$];

    // Behavioural RAM/stack block
    logic        ramClear;
    logic [31:0] ramMem [0:MemDepth-1];
    logic [31:0] ramStk [0:StkDepth-1];
    logic [31:0] rdPipe [0:ReadLat-1];

    mem_access_ctrl #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .MEM_DEPTH (MemDepth),
        .STK_DEPTH (StkDepth),
        .READ_LAT  (ReadLat)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqOp        (ReqOp),
        .ReqAddr      (ReqAddr),
        .ReqData      (ReqData),
        .RspValid     (RspValid),
        .RspData      (RspData),
        .RspErr       (RspErr),
        .MemAddr      (MemAddr),
        .MemDataIn    (MemDataIn),
        .MemWrite     (MemWrite),
        .MemUseStk    (MemUseStk),
        .MemDataOut   (MemDataOut),
        .StackPointer (StackPointer),
        .StkFull      (StkFull),
        .StkEmpty     (StkEmpty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (ramClear) begin
            for (int i = 0; i < MemDepth; i++) begin
                ramMem[i] <= '0;
                ramStk[i] <= '0;
            end
        end else if (MemWrite && MemAddr < MemDepth) begin
            if (MemUseStk) ramStk[MemAddr[7:0]] <= MemDataIn;
            else           ramMem[MemAddr[7:0]] <= MemDataIn;
        end
        if (MemAddr < MemDepth)
            rdPipe[0] <= MemUseStk ? ramStk[MemAddr[7:0]] : ramMem[MemAddr[7:0]];
        else
            rdPipe[0] <= '0;
        for (int s = 1; s < ReadLat; s++) rdPipe[s] <= rdPipe[s-1];
    end
    assign MemDataOut = rdPipe[ReadLat-1];

    // Spec-level expectation for one request; updates the model state
    function automatic void ref_step(input logic [1:0] op, input logic [31:0] addr,
                                     input logic [31:0] data, output logic expErr,
                                     output logic [31:0] expData, output int expLat,
                                     output logic [31:0] expAddr);
        expErr = 1'b0; expData = '0; expAddr = '0; expLat = 2;
        case (op)
            LD: if (addr >= MemDepth) expErr = 1'b1;
                else begin
                    expData = refMem[addr[7:0]]; expAddr = addr; expLat = 2 + ReadLat;
                end
            ST: if (addr >= MemDepth) expErr = 1'b1;
                else begin
                    refMem[addr[7:0]] = data; expAddr = addr;
                end
            PU: if (refStack.size() >= StkDepth) expErr = 1'b1;
                else begin
                    expAddr = 32'(refStack.size()); refStack.push_back(data);
                end
            default: if (refStack.size() == 0) expErr = 1'b1;
                else begin
                    expAddr = 32'(refStack.size() - 1); expData = refStack.pop_back();
                    expLat = 2 + ReadLat;
                end
        endcase
        if (expErr) expLat = 1;
    endfunction

    // Drive one request and observe its response; lat = -1 on timeout
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int wrPulses, output logic issWr, output logic [31:0] issAddr,
                          output logic issStk);
        int guard;
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = op; ReqAddr = addr; ReqData = data;
        guard = 0;
        while (!ReqReady && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        @(negedge Clock);
        ReqValid = 1'b0;
        lat = 1; wrPulses = 0;
        issWr = MemWrite; issAddr = MemAddr; issStk = MemUseStk;
        while (!RspValid && lat < 40) begin
            if (MemWrite) wrPulses++;
            @(negedge Clock);
            lat++;
        end
        err = RspErr; rdata = RspData;
        if (!RspValid) lat = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; ramClear = 1'b1; ReqValid = 1'b0;
        ReqOp = LD; ReqAddr = '0; ReqData = '0;
        for (int i = 0; i < MemDepth; i++) refMem[i] = '0;
        refStack.delete();
        repeat (2) @(negedge Clock);
        nChecks++;
        if (MemWrite !== 1'b0 || RspValid !== 1'b0) begin
            nFails++;
            $display("FAIL reset_held: MemWrite=%b RspValid=%b expected 0 0", MemWrite, RspValid);
        end
        Reset = 1'b0; ramClear = 1'b0;
        nChecks++;
        if ({StackPointer, StkEmpty, StkFull, ReqReady, RspValid, MemWrite, RspErr} !==
            {32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            nFails++;
            $display("FAIL reset_state: SP=%0d E=%b F=%b Rdy=%b RV=%b MW=%b RE=%b expected 0 1 0 1 0 0 0",
                     StackPointer, StkEmpty, StkFull, ReqReady, RspValid, MemWrite, RspErr);
        end
    endtask

    task automatic test_store_load();
        int lat, wp, eLat; logic err, iw, is, eErr; logic [31:0] rd, ia, eData, eAddr;
        ref_step(ST, 32'd5, 32'hDEADBEEF, eErr, eData, eLat, eAddr);
        do_req(ST, 32'd5, 32'hDEADBEEF, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (ia !== 32'd5 || iw !== 1'b1 || is !== 1'b0) begin
            nFails++;
            $display("FAIL store_issue: addr=%0d wr=%b stk=%b expected 5 1 0", ia, iw, is);
        end
        nChecks++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'd0) begin
            nFails++;
            $display("FAIL store_rsp: lat=%0d err=%b data=%h expected 2 0 0", lat, err, rd);
        end
        ref_step(LD, 32'd5, 32'h0, eErr, eData, eLat, eAddr);
        do_req(LD, 32'd5, 32'h0, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (lat != 2 + ReadLat || err !== 1'b0 || rd !== 32'hDEADBEEF || wp != 0) begin
            nFails++;
            $display("FAIL load_rsp: lat=%0d err=%b data=%h wr=%0d expected %0d 0 deadbeef 0",
                     lat, err, rd, wp, 2 + ReadLat);
        end
    endtask

    task automatic test_push_pop();
        int lat, wp, eLat; logic err, iw, is, eErr; logic [31:0] rd, ia, eData, eAddr;
        logic [31:0] vals [0:2];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            ref_step(PU, 32'h0, vals[i], eErr, eData, eLat, eAddr);
            do_req(PU, 32'h0, vals[i], lat, err, rd, wp, iw, ia, is);
            nChecks++;
            if (StackPointer !== 32'(i + 1) || ia !== 32'(i) || is !== 1'b1 || iw !== 1'b1
                || err !== 1'b0 || lat != 2) begin
                nFails++;
                $display("FAIL push_%0d: SP=%0d addr=%0d stk=%b wr=%b err=%b lat=%0d expected %0d %0d 1 1 0 2",
                         i, StackPointer, ia, is, iw, err, lat, i + 1, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ref_step(PO, 32'h0, 32'h0, eErr, eData, eLat, eAddr);
            do_req(PO, 32'h0, 32'h0, lat, err, rd, wp, iw, ia, is);
            nChecks++;
            if (rd !== vals[2-i] || ia !== 32'(2 - i) || StackPointer !== 32'(2 - i)
                || err !== 1'b0 || lat != 2 + ReadLat || wp != 0) begin
                nFails++;
                $display("FAIL pop_%0d: data=%h addr=%0d SP=%0d err=%b lat=%0d wr=%0d expected %h %0d %0d 0 %0d 0",
                         i, rd, ia, StackPointer, err, lat, wp, vals[2-i], 2 - i, 2 - i, 2 + ReadLat);
            end
        end
        nChecks++;
        if (StkEmpty !== 1'b1) begin
            nFails++;
            $display("FAIL pop_empty_flag: StkEmpty=%b expected 1", StkEmpty);
        end
    endtask

    task automatic test_stack_bounds();
        int lat, wp, eLat, bad; logic err, iw, is, eErr; logic [31:0] rd, ia, eData, eAddr, d;
        ref_step(PO, 32'h0, 32'h0, eErr, eData, eLat, eAddr);
        do_req(PO, 32'h0, 32'h0, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (err !== 1'b1 || lat != 1 || iw !== 1'b0 || wp != 0 || StackPointer !== 32'd0 || rd !== 32'd0) begin
            nFails++;
            $display("FAIL pop_on_empty: err=%b lat=%0d wr=%b/%0d SP=%0d data=%h expected 1 1 0/0 0 0",
                     err, lat, iw, wp, StackPointer, rd);
        end
        bad = 0;
        for (int i = 0; i < StkDepth; i++) begin
            d = $urandom;
            ref_step(PU, 32'h0, d, eErr, eData, eLat, eAddr);
            do_req(PU, 32'h0, d, lat, err, rd, wp, iw, ia, is);
            if (err !== eErr || lat != eLat || ia !== eAddr) bad++;
        end
        nChecks++;
        if (bad != 0 || StkFull !== 1'b1 || StackPointer !== 32'd200) begin
            nFails++;
            $display("FAIL fill_stack: bad=%0d StkFull=%b SP=%0d expected 0 1 200", bad, StkFull, StackPointer);
        end
        ref_step(PU, 32'h0, 32'hABCD, eErr, eData, eLat, eAddr);
        do_req(PU, 32'h0, 32'hABCD, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (err !== 1'b1 || lat != 1 || StackPointer !== 32'd200 || iw !== 1'b0 || wp != 0) begin
            nFails++;
            $display("FAIL push_on_full: err=%b lat=%0d SP=%0d wr=%b/%0d expected 1 1 200 0/0",
                     err, lat, StackPointer, iw, wp);
        end
        for (int i = 0; i < 4; i++) begin
            ref_step(PO, 32'h0, 32'h0, eErr, eData, eLat, eAddr);
            do_req(PO, 32'h0, 32'h0, lat, err, rd, wp, iw, ia, is);
            nChecks++;
            if (rd !== eData || ia !== eAddr || err !== eErr || StkFull !== 1'b0) begin
                nFails++;
                $display("FAIL pop_from_full_%0d: data=%h addr=%0d err=%b full=%b expected %h %0d %b 0",
                         i, rd, ia, err, StkFull, eData, eAddr, eErr);
            end
        end
    endtask

    task automatic test_addr_errors();
        int lat, wp, eLat; logic err, iw, is, eErr; logic [31:0] rd, ia, eData, eAddr;
        ref_step(LD, 32'd200, 32'h0, eErr, eData, eLat, eAddr);
        do_req(LD, 32'd200, 32'h0, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat != 1 || iw !== 1'b0) begin
            nFails++;
            $display("FAIL load_oob: err=%b data=%h lat=%0d wr=%b expected 1 0 1 0", err, rd, lat, iw);
        end
        ref_step(ST, 32'hFFFFFFFF, 32'h5A5A5A5A, eErr, eData, eLat, eAddr);
        do_req(ST, 32'hFFFFFFFF, 32'h5A5A5A5A, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat != 1 || iw !== 1'b0 || wp != 0) begin
            nFails++;
            $display("FAIL store_oob: err=%b data=%h lat=%0d wr=%b/%0d expected 1 0 1 0/0",
                     err, rd, lat, iw, wp);
        end
        ref_step(ST, 32'd199, 32'h0BADF00D, eErr, eData, eLat, eAddr);
        do_req(ST, 32'd199, 32'h0BADF00D, lat, err, rd, wp, iw, ia, is);
        ref_step(LD, 32'd199, 32'h0, eErr, eData, eLat, eAddr);
        do_req(LD, 32'd199, 32'h0, lat, err, rd, wp, iw, ia, is);
        nChecks++;
        if (err !== 1'b0 || rd !== 32'h0BADF00D || ia !== 32'd199) begin
            nFails++;
            $display("FAIL load_last_word: err=%b data=%h addr=%0d expected 0 0badf00d 199", err, rd, ia);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, wp, eLat, seen; logic err, iw, is, eErr; logic [31:0] rd, ia, eData, eAddr;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        refStack.delete();
        for (int i = 0; i < 3; i++) begin
            ref_step(PU, 32'h0, 32'(i + 100), eErr, eData, eLat, eAddr);
            do_req(PU, 32'h0, 32'(i + 100), lat, err, rd, wp, iw, ia, is);
        end
        nChecks++;
        if (StackPointer !== 32'd3) begin
            nFails++;
            $display("FAIL rst_mid_setup: SP=%0d expected 3", StackPointer);
        end
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = PO;
        @(negedge Clock);
        ReqValid = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        refStack.delete();
        nChecks++;
        if (ReqReady !== 1'b1 || StackPointer !== 32'd0 || StkEmpty !== 1'b1) begin
            nFails++;
            $display("FAIL rst_mid_state: Rdy=%b SP=%0d E=%b expected 1 0 1", ReqReady, StackPointer, StkEmpty);
        end
        seen = 0;
        repeat (2 + ReadLat + 3) begin
            if (RspValid) seen++;
            @(negedge Clock);
        end
        nChecks++;
        if (seen != 0) begin
            nFails++;
            $display("FAIL rst_mid_no_rsp: RspValid pulses=%0d expected 0", seen);
        end
    endtask

    task automatic test_held_valid();
        int acc, pulses, eLat; logic eErr; logic [31:0] got, eData, eAddr;
        ref_step(LD, 32'd5, 32'h0, eErr, eData, eLat, eAddr);
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = LD; ReqAddr = 32'd5;
        acc = 0; pulses = 0; got = '0;
        for (int c = 0; c < 2 + ReadLat + 5; c++) begin
            if (ReqValid && ReqReady) acc++;
            if (RspValid) begin
                pulses++;
                got = RspData;
                ReqValid = 1'b0;
            end
            @(negedge Clock);
        end
        ReqValid = 1'b0;
        nChecks++;
        if (acc != 1 || pulses != 1 || got !== eData) begin
            nFails++;
            $display("FAIL held_valid: accepts=%0d rsps=%0d data=%h expected 1 1 %h", acc, pulses, got, eData);
        end
    endtask

    task automatic test_random();
        int lat, wp, eLat; logic err, iw, is, eErr; logic [31:0] rd, ia, eData, eAddr, a, d;
        logic [1:0] op;
        for (int n = 0; n < 250; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 32'hFFFFFFFF;
                1:       a = 32'($urandom_range(200, 300));
                default: a = 32'($urandom_range(0, 199));
            endcase
            d = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            ref_step(op, a, d, eErr, eData, eLat, eAddr);
            do_req(op, a, d, lat, err, rd, wp, iw, ia, is);
            nChecks++;
            if (err !== eErr || rd !== eData || lat != eLat) begin
                nFails++;
                $display("FAIL rand_rsp_%0d: op=%0d addr=%h err=%b data=%h lat=%0d expected %b %h %0d",
                         n, op, a, err, rd, lat, eErr, eData, eLat);
            end
            nChecks++;
            if (StackPointer !== 32'(refStack.size()) || StkEmpty !== (refStack.size() == 0)
                || StkFull !== (refStack.size() == StkDepth)) begin
                nFails++;
                $display("FAIL rand_sp_%0d: SP=%0d E=%b F=%b expected %0d", n, StackPointer, StkEmpty,
                         StkFull, refStack.size());
            end
            if (!eErr) begin
                nChecks++;
                if (ia !== eAddr || is !== op[1] || iw !== (op == ST || op == PU) || wp != 32'(iw)) begin
                    nFails++;
                    $display("FAIL rand_issue_%0d: addr=%h stk=%b wr=%b/%0d expected %h %b %b",
                             n, ia, is, iw, wp, eAddr, op[1], (op == ST || op == PU));
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_push_pop();
        test_stack_bounds();
        test_addr_errors();
        test_reset_mid_op();
        test_held_valid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Request sequencer placed directly upstream of the RAM/stack block. It takes one load, store, push or pop request at a time from the core through a valid/ready handshake. It owns the stack pointer and drives the address, write-enable, stack-select and write-data inputs of the RAM/stack block. It waits out the RAM's registered read latency and returns one response per request with an error flag.

Parameters:
DATA_W, 32, data width
ADDR_W, 32, address width of request and memory ports
MEM_DEPTH, 200, number of valid RAM words (addresses 0..MEM_DEPTH-1)
STK_DEPTH, 200, number of stack words
READ_LAT, 1, cycles from address issue until MemDataOut is valid (minimum 1)

Ports:
Clock  in  1  single system clock, rising edge
Reset  in  1  synchronous, active-high reset
ReqValid  in  1  request present
ReqReady  out  1  controller can accept a request
ReqOp  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
ReqAddr  in  ADDR_W  word address for LOAD/STORE (ignored for PUSH/POP)
ReqData  in  DATA_W  write data for STORE/PUSH
RspValid  out  1  one-cycle response pulse
RspData  out  DATA_W  read data for LOAD/POP; 0 otherwise
RspErr  out  1  request rejected; valid while RspValid=1
MemAddr  out  ADDR_W  to RAM Addr
MemDataIn  out  DATA_W  to RAM DataIn
MemWrite  out  1  to RAM WriteMem
MemUseStk  out  1  to RAM useStk
MemDataOut  in  DATA_W  from RAM DataOut
StackPointer  out  ADDR_W  current entry count, zero-extended
StkFull  out  1  StackPointer == STK_DEPTH
StkEmpty  out  1  StackPointer == 0

Behaviour:
- Reset values:
  - state IDLE; all outputs 0 except ReqReady=1 and StkEmpty=1.
  - StackPointer=0.
  - MemWrite is gated low while Reset=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ReqReady=1; handshake when ReqValid&ReqReady.
  - The request is captured on that edge.
  - If the request is an error, go to RESP. Otherwise go to ISSUE.
- Error conditions:
  - LOAD/STORE with ReqAddr >= MEM_DEPTH.
  - PUSH when StkFull.
  - POP when StkEmpty.
  - An error performs no memory access and leaves SP unchanged.
- ISSUE (one cycle):
  - MemAddr, MemUseStk and MemDataIn driven from the captured request.
  - STORE/PUSH: MemWrite=1 for this cycle only, then go to RESP.
  - LOAD/POP: MemWrite=0, then go to WAIT.
- Stack addressing:
  - PUSH: MemAddr=SP; SP increments at the end of ISSUE.
  - POP: MemAddr=SP-1; SP decrements at the end of ISSUE.
- WAIT:
  - Lasts READ_LAT cycles with MemAddr and MemUseStk held stable.
  - MemDataOut is registered into RspData on the last WAIT edge, then go to RESP.
- RESP:
  - RspValid=1 for exactly one cycle, then go to IDLE.
  - RspErr=1 only for error requests.
  - RspData=0 for STORE, PUSH and all errors.
- ReqReady=0 in ISSUE, WAIT and RESP. ReqValid is ignored there, so a held request is taken only on return to IDLE.
- Latency, counting the handshake edge as cycle 0:
  - error: RspValid in cycle 1
  - STORE/PUSH: cycle 2
  - LOAD/POP: cycle 2+READ_LAT
- Throughput: one request in flight; no back-to-back acceptance in RESP.
- Mem* outputs are registered. They keep their last values in IDLE/RESP, except MemWrite=0.
- Internal SP width is clog2(STK_DEPTH+1). No wrap-around: full and empty are guarded.
- Reset mid-operation:
  - Any in-flight request is aborted with no RspValid.
  - SP=0, so stack contents are logically discarded.
  - ReqReady=1 on the first cycle after Reset deasserts.

Decomposition:
- Package mem_pkg holds:
  - op encodings LOAD/STORE/PUSH/POP
  - FSM state enum
  - default MEM_DEPTH/STK_DEPTH constants
- Sub-module stack_pointer_ctr:
  - SP register with inc/dec strobes
  - Full/Empty outputs and synchronous reset
  - Instantiated once.

Test Plan:
- Reset for 2 cycles -> StackPointer=0, StkEmpty=1, StkFull=0, ReqReady=1, RspValid=0, MemWrite=0.
- STORE addr 5 data 0xDEADBEEF -> cycle 1: MemAddr=5, MemWrite=1, MemUseStk=0; cycle 2: RspValid=1, RspErr=0. Then LOAD addr 5 -> RspValid at cycle 3 with RspData=0xDEADBEEF.
- PUSH 0x11, 0x22, 0x33 then three POPs -> SP goes 1,2,3 then 2,1,0; POP data 0x33, 0x22, 0x11; MemAddr for pops 2,1,0; StkEmpty=1 at end.
- POP on empty -> RspErr=1 in cycle 1, MemWrite never 1, SP=0. Then 200 PUSHes -> StkFull=1; 201st PUSH gives RspErr=1 and SP stays 200.
- LOAD addr 200 and STORE addr 0xFFFFFFFF -> RspErr=1, RspData=0, no MemWrite pulse.
- Reset asserted during WAIT of a POP with SP=3 -> no RspValid, SP=0; ReqReady=1 the cycle after Reset deasserts; ReqValid held high during a busy LOAD is accepted only once.
